// File: rtl/kmeans_pkg.sv
// Shared widths, packing offsets and FSM states for the k-means mean update block.
package kmeans_pkg;

  localparam int unsigned CH     = 3;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned SUM_W  = 24;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned MEAN_W = CH * CH_W;   // per-cluster mean packing
  localparam int unsigned ACC_W  = CH * SUM_W;  // per-cluster accumulator packing
  localparam int unsigned DVD_W  = SUM_W + 1;   // merged sum of two engines
  localparam int unsigned DVS_W  = CNT_W + 1;   // merged count of two engines
  localparam int unsigned DCNT_W = 5;

  localparam logic [1:0] C_LAST = 2'(CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_STORE,
    ST_DONE
  } state_e;

  function automatic logic [CH_W-1:0] sat_mean(input logic [DVD_W-1:0] q);
    return (|q[DVD_W-1:CH_W]) ? '1 : q[CH_W-1:0];
  endfunction

endpackage

// File: rtl/kmeans_udiv_serial.sv
// Restoring serial unsigned divider: one quotient bit per cycle, valid 25 cycles after start.
module kmeans_udiv_serial
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [DVD_W-1:0] quotient
);

  logic [DVS_W-1:0]  rem_q, rem_d, dvs_q, dvs_d, rem_in, dvs_in;
  logic [DVD_W-1:0]  quo_q, quo_d, quo_in;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d, valid_q, valid_d;
  logic [DVS_W:0]    trial;
  logic              fits;

  // The first step is taken on the start edge itself, so 24 more remain.
  always_comb begin
    rem_in  = start ? '0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    dvs_in  = start ? divisor : dvs_q;
    trial   = {rem_in, quo_in[DVD_W-1]};
    fits    = (trial >= {1'b0, dvs_in});
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (start || busy_q) begin
      rem_d = fits ? DVS_W'(trial - {1'b0, dvs_in}) : trial[DVS_W-1:0];
      quo_d = {quo_in[DVD_W-2:0], fits};
      dvs_d = dvs_in;
      if (start) begin
        cnt_d  = DCNT_W'(DVD_W - 1);
        busy_d = 1'b1;
      end else begin
        cnt_d = cnt_q - DCNT_W'(1);
        if (cnt_q == DCNT_W'(1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign quotient = quo_q;

endmodule

// File: rtl/kmeans_mean_update.sv
// Merges two engines' cluster sums/counts and divides to form next means.
// Optional convergence detection is compiled in with KMEANS_CONVERGE_CHECK_EN.
module kmeans_mean_update
  import kmeans_pkg::*;
#(
  parameter int unsigned T = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  loadInit,
  input  logic [T*MEAN_W-1:0]   meanInit,
  input  logic [T-1:0]          enabled,
  input  logic [2*T*ACC_W-1:0]  accumolator,
  input  logic [2*T*CNT_W-1:0]  counters,
  input  logic [CH_W-1:0]       threshold,
  output logic [T*MEAN_W-1:0]   meanOut,
  output logic                  busy,
  output logic                  done,
  output logic                  converged
);

  localparam int unsigned KW = (T > 1) ? $clog2(T) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(T - 1);

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [1:0]            c_q, c_d;
  logic [T*MEAN_W-1:0]   shadow_q, shadow_d, mean_q, mean_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [1:0]            div_ch;
  logic                  div_start, div_valid, div_busy_unused, upd;
  logic [DVD_W-1:0]      dividend, quotient;
  logic [DVS_W-1:0]      cnt_sum;
  logic [CH_W-1:0]       q_sat;
  int unsigned           acc_base, cnt_base, mean_base;

  always_comb begin
    div_ch    = (state_q == ST_STORE) ? c_q + 2'd1 : 2'd0;
    acc_base  = ACC_W * 32'(k_q) + SUM_W * 32'(div_ch);
    cnt_base  = CNT_W * 32'(k_q);
    mean_base = MEAN_W * 32'(k_q) + CH_W * 32'(c_q);
    dividend  = {1'b0, accumolator[acc_base +: SUM_W]}
              + {1'b0, accumolator[T*ACC_W + acc_base +: SUM_W]};
    cnt_sum   = {1'b0, counters[cnt_base +: CNT_W]}
              + {1'b0, counters[T*CNT_W + cnt_base +: CNT_W]};
    upd       = enabled[k_q] && (cnt_sum != '0);
    div_start = ((state_q == ST_LOAD) && upd) || ((state_q == ST_STORE) && (c_q != C_LAST));
    q_sat     = sat_mean(quotient);
  end

  kmeans_udiv_serial u_div (
    .clk      (clk),
    .rst_n    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cnt_sum),
    .busy     (div_busy_unused),
    .valid    (div_valid),
    .quotient (quotient)
  );

  // Cluster advance happens directly out of LOAD (skip) or the last STORE,
  // so a skipped cluster costs one cycle and an updated one 1+3*26.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    c_d      = c_q;
    shadow_d = shadow_q;
    mean_d   = mean_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          k_d      = '0;
          c_d      = '0;
          shadow_d = mean_q;
        end else if (loadInit) begin
          mean_d = meanInit;
        end
      end
      ST_LOAD: begin
        if (upd) begin
          state_d = ST_DIV;
          c_d     = '0;
        end else if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DIV: begin
        if (div_valid) state_d = ST_STORE;
      end
      ST_STORE: begin
        shadow_d[mean_base +: CH_W] = q_sat;
        if (c_q != C_LAST) begin
          state_d = ST_DIV;
          c_d     = c_q + 2'd1;
        end else if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          k_d     = k_q + KW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d inside {ST_LOAD, ST_DIV, ST_STORE});
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) mean_d = shadow_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      c_q      <= '0;
      shadow_q <= '0;
      mean_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      c_q      <= c_d;
      shadow_q <= shadow_d;
      mean_q   <= mean_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef KMEANS_CONVERGE_CHECK_EN
  logic            moved_q, moved_d, conv_q, conv_d;
  logic [CH_W-1:0] old_m, delta;

  always_comb begin
    old_m   = mean_q[mean_base +: CH_W];
    delta   = (q_sat >= old_m) ? q_sat - old_m : old_m - q_sat;
    moved_d = moved_q;
    conv_d  = conv_q;
    if (state_q == ST_IDLE && start) begin
      moved_d = 1'b0;
      conv_d  = 1'b0;
    end else begin
      if (state_q == ST_STORE && delta > threshold) moved_d = 1'b1;
      if (state_d == ST_DONE) conv_d = !moved_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      moved_q <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      moved_q <= moved_d;
      conv_q  <= conv_d;
    end
  end

  assign converged = conv_q;
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign converged        = 1'b0;
`endif

  assign meanOut = mean_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_kmeans_mean_update.sv
// Directed table-driven bench for kmeans_mean_update plus reset/restart corner sequences.
module tb_kmeans_mean_update;

  localparam int T  = 16;
  localparam int MW = T * 24;

`ifdef KMEANS_CONVERGE_CHECK_EN
  localparam bit CONV_ON = 1'b1;
`else
  localparam bit CONV_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, loadInit;
  logic [MW-1:0]     meanInit;
  logic [T-1:0]      enabled;
  logic [72*T*2-1:0] accumolator;
  logic [12*T*2-1:0] counters;
  logic [7:0]        threshold;
  logic [MW-1:0]     meanOut;
  logic              busy, done, converged;

  int n_cmp = 0;
  int n_bad = 0;

  kmeans_mean_update #(.T(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .loadInit    (loadInit),
    .meanInit    (meanInit),
    .enabled     (enabled),
    .accumolator (accumolator),
    .counters    (counters),
    .threshold   (threshold),
    .meanOut     (meanOut),
    .busy        (busy),
    .done        (done),
    .converged   (converged)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        en;
    logic [23:0] init;
    logic [71:0] s0;
    logic [71:0] s1;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [23:0] exp;
    int          lat;
    logic        conv;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(int k, logic en, logic [23:0] init, logic [71:0] s0, logic [71:0] s1,
                              logic [11:0] c0, logic [11:0] c1, logic [23:0] exp, int lat, logic conv);
    vec_t v;
    v.k = k; v.en = en; v.init = init; v.s0 = s0; v.s1 = s1;
    v.c0 = c0; v.c1 = c1; v.exp = exp; v.lat = lat; v.conv = conv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Applies a vector's inputs and loads a known mean set; returns that set and the expected result.
  task automatic setup_vec(input vec_t v, output logic [MW-1:0] fi, output logic [MW-1:0] ef);
    accumolator = '0;
    counters    = '0;
    enabled     = '0;
    enabled[v.k] = v.en;
    accumolator[72*v.k +: 72]       = v.s0;
    accumolator[72*T + 72*v.k +: 72] = v.s1;
    counters[12*v.k +: 12]          = v.c0;
    counters[12*T + 12*v.k +: 12]   = v.c1;
    for (int j = 0; j < T; j++) fi[24*j +: 24] = {8'(3*j + 5), 8'(2*j + 3), 8'(j + 1)};
    fi[24*v.k +: 24] = v.init;
    ef = fi;
    ef[24*v.k +: 24] = v.exp;
    meanInit = fi;
    loadInit = 1'b1;
    tick;
    loadInit = 1'b0;
    chk("loadinit", meanOut, fi);
  endtask

  task automatic run_pass(input logic [MW-1:0] hold, output int lat);
    int cyc;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == 10) begin
        chk("mean_stable", meanOut, hold);
        chk("busy_mid", busy, 1'b1);
      end
      tick;
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1 within 400", done, cyc);
      lat = -1;
    end else begin
      lat = cyc;
    end
  endtask

  initial begin
    logic [MW-1:0] fi, ef, save, expm;
    int lat, ndone, first, cyc;

    vecs[0] = mk(0, 1'b1, 24'h000000, {24'd900, 24'd600, 24'd300}, {24'd300, 24'd200, 24'd100},
                 12'd3, 12'd1, 24'hFFC864, 95, 1'b0);
    vecs[1] = mk(5, 1'b1, 24'h000101, {24'd0, 24'd11, 24'd10}, 72'd0,
                 12'd3, 12'd0, 24'h000303, 95, 1'b1);
    vecs[2] = mk(3, 1'b1, 24'h463C32, {24'd139, 24'd120, 24'd100}, {24'd0, 24'd1, 24'd4},
                 12'd1, 12'd1, 24'h453C34, 95, 1'b1);
    vecs[3] = mk(3, 1'b1, 24'h463C32, {24'd139, 24'd120, 24'd100}, {24'd0, 24'd1, 24'd6},
                 12'd1, 12'd1, 24'h453C35, 95, 1'b0);
    vecs[4] = mk(2, 1'b1, 24'h1E140A, {24'd5, 24'd5, 24'd5}, 72'd0,
                 12'd0, 12'd0, 24'h1E140A, 17, 1'b1);
    vecs[5] = mk(7, 1'b0, 24'h0A0B0C, {24'd50, 24'd50, 24'd50}, 72'd0,
                 12'd5, 12'd0, 24'h0A0B0C, 17, 1'b1);
    vecs[6] = mk(15, 1'b1, 24'h0007FE, {24'd0, 24'd65519, 24'hFFFFFF}, {24'd0, 24'd0, 24'hFFFFFF},
                 12'd4095, 12'd4095, 24'h0007FF, 95, 1'b1);
    vecs[7] = mk(1, 1'b1, 24'h000000, 72'd0, {24'd1, 24'd4, 24'd9},
                 12'd0, 12'd2, 24'h000204, 95, 1'b0);

    reset = 1'b0; start = 1'b0; loadInit = 1'b0; meanInit = '0; enabled = '0;
    accumolator = '0; counters = '0; threshold = 8'd2;
    tick;
    tick;
    chk("rst_mean", meanOut, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_conv", converged, 1'b0);
    reset = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) begin
      setup_vec(vecs[i], fi, ef);
      run_pass(fi, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_mean", i), meanOut, ef);
      chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      chk($sformatf("v%0d_conv", i), converged, CONV_ON ? vecs[i].conv : 1'b0);
      tick;
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
      chk($sformatf("v%0d_conv_held", i), converged, CONV_ON ? vecs[i].conv : 1'b0);
    end

    // Reset asserted mid-pass aborts everything; a following pass starts from zero means.
    setup_vec(vecs[0], fi, ef);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (30) tick;
    reset = 1'b0;
    tick;
    tick;
    chk("midrst_mean", meanOut, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    reset = 1'b1;
    ndone = 0;
    for (int j = 0; j < 120; j++) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_pass('0, lat);
    expm = '0;
    expm[23:0] = 24'hFFC864;
    chk("midrst_rerun_lat", lat, 95);
    chk("midrst_rerun_mean", meanOut, expm);
    tick;

    // Extra start pulses while busy are ignored.
    setup_vec(vecs[0], fi, ef);
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1; ndone = 0; first = -1;
    for (int j = 0; j < 130; j++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = cyc;
      end
      if (cyc == 10 || cyc == 60) start = 1'b1;
      tick;
      start = 1'b0;
      cyc++;
    end
    chk("restart_ndone", ndone, 1);
    chk("restart_lat", first, 95);
    chk("restart_mean", meanOut, ef);

    // start beats loadInit; with nothing enabled the means are untouched.
    save = meanOut;
    accumolator = '0;
    counters = '0;
    enabled = '0;
    meanInit = ~save;
    loadInit = 1'b1;
    run_pass(save, lat);
    loadInit = 1'b0;
    chk("prio_lat", lat, 17);
    chk("prio_mean", meanOut, save);
    chk("prio_conv", converged, CONV_ON);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
